// File: rtl/spi_sniff_pkg.sv
// Shared definitions for the SPI frame sniffer.
//   state_e            : capture FSM states
//   FRAME_BITS_DEFAULT : header + data bits of the default sensor frame
//   SYNC_DEPTH         : flop count of each input synchroniser
package spi_sniff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam int FRAME_BITS_DEFAULT = 24;
  localparam int DATA_BITS_DEFAULT  = 16;
  localparam int HDR_BITS_DEFAULT   = FRAME_BITS_DEFAULT - DATA_BITS_DEFAULT;
  localparam int SYNC_DEPTH         = 2;

endpackage

// File: rtl/spi_frame_sniffer_sync_2ff.sv
// Generic 1-bit multi-flop synchroniser (SYNC_DEPTH flops, two by default).
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset; flops load RST_VAL
//   d_i    : asynchronous input
//   q_o    : synchronised output
module sync_2ff
  import spi_sniff_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= {SYNC_DEPTH{RST_VAL}};
    end else begin
      ff_q <= {ff_q[SYNC_DEPTH-2:0], d_i};
    end
  end

  assign q_o = ff_q[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_frame_sniffer.sv
// Passive SPI read-frame sniffer: oversamples sck/cs/miso on clk, discards the
// header, and presents each good frame's data field with a valid/ready handshake.
//   clk, rst_n         : system clock (>= 4x sck), async active-low reset
//   spi_sck/cs/miso    : raw shared SPI bus (mode 0), listen-only
//   z_data, z_valid    : captured measurement and its valid flag
//   z_ready            : consumer accepts when z_valid && z_ready
//   frame_err          : one-cycle pulse, frame length != HDR_BITS+DATA_BITS
//   overrun            : sticky, a good frame replaced an unaccepted sample
//
// state    | meaning
// ST_IDLE  | waiting for cs falling edge
// ST_SHIFT | cs low, shifting miso on each sck rise
// ST_CHECK | one cycle: judge bit count, publish or flag error
module spi_frame_sniffer
  import spi_sniff_pkg::*;
#(
  parameter int HDR_BITS  = HDR_BITS_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int BYTE_SWAP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_sck,
  input  logic                 spi_cs,
  input  logic                 spi_miso,
  output logic [DATA_BITS-1:0] z_data,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int FRAME_BITS = HDR_BITS + DATA_BITS;
  localparam int CNT_MAX    = FRAME_BITS + 1;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int FL_W       = $clog2(SYNC_DEPTH + 1);

  logic sck_s, cs_s, miso_s;
  logic sck_dly_q, cs_dly_q;
  logic sck_rise, cs_fall, cs_rise;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] z_data_q, z_data_d;
  logic                 z_valid_q, z_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [FL_W-1:0]      flush_q, flush_d;
  logic                 armed_q, armed_d;
  logic                 flushed;
  logic [DATA_BITS-1:0] cap;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .d_i(spi_sck),  .q_o(sck_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d_i(spi_cs),   .q_o(cs_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_miso (.clk(clk), .rst_n(rst_n), .d_i(spi_miso), .q_o(miso_s));

  assign sck_rise = sck_s & ~sck_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;

  if (BYTE_SWAP != 0 && DATA_BITS == 16) begin : g_swap
    assign cap = {shift_q[7:0], shift_q[15:8]};
  end else begin : g_noswap
    assign cap = shift_q;
  end

  // The synchroniser reset values fake an idle bus. If raw cs is already low
  // when reset releases, that would look like a fresh cs_fall in the middle of
  // a frame. Frame starts are only honoured once a real (post-flush) cs high
  // has been observed.
  assign flushed = (flush_q == FL_W'(SYNC_DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    z_data_d    = z_data_q;
    z_valid_d   = z_valid_q & ~z_ready;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    flush_d     = flushed ? flush_q : flush_q + 1'b1;
    armed_d     = armed_q | (flushed & cs_s);

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A coincident sck rise is shifted before leaving for CHECK.
        if (sck_rise) begin
          shift_d = {shift_q[DATA_BITS-2:0], miso_s};
          if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + 1'b1;
        end
        if (cs_rise) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (cnt_q == CNT_W'(FRAME_BITS)) begin
          z_data_d  = cap;
          z_valid_d = 1'b1;
          if (z_valid_q && !z_ready) overrun_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      z_data_q    <= '0;
      z_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      z_data_q    <= z_data_d;
      z_valid_q   <= z_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign z_data    = z_data_q;
  assign z_valid   = z_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_frame_sniffer.sv
// Directed bench for spi_frame_sniffer: clk period 10 ns, sck = clk/8.
module tb_spi_frame_sniffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sck, spi_cs, spi_miso;
  logic        z_ready;
  logic        sw_ready;
  logic [15:0] z_data, sw_data;
  logic        z_valid, frame_err, overrun;
  logic        sw_valid, sw_ferr, sw_ovr;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0;
  int n_vrise = 0;
  logic zv_prev = 1'b0;

  always #5 clk = ~clk;

  spi_frame_sniffer dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_miso(spi_miso),
    .z_data(z_data), .z_valid(z_valid), .z_ready(z_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  spi_frame_sniffer #(.BYTE_SWAP(1)) dut_sw (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_miso(spi_miso),
    .z_data(sw_data), .z_valid(sw_valid), .z_ready(sw_ready),
    .frame_err(sw_ferr), .overrun(sw_ovr)
  );

  // Event counters for windows where any pulse at all is an error.
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (z_valid && !zv_prev) n_vrise++;
    zv_prev = z_valid;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int hi, input int lo, input logic [31:0] v);
    for (int i = hi; i >= lo; i--) begin
      spi_sck  = 1'b0;
      spi_miso = v[i];
      tick(4);
      spi_sck = 1'b1;
      tick(4);
    end
  endtask

  // Full frame of n bits, MSB first. With coincide set, the last sck rise and
  // the cs rise are driven in the same cycle.
  task automatic frame(input int n, input logic [31:0] v, input bit coincide);
    spi_cs = 1'b0;
    tick(4);
    if (coincide) begin
      send_bits(n - 1, 1, v);
      spi_sck  = 1'b0;
      spi_miso = v[0];
      tick(4);
      spi_sck = 1'b1;
      spi_cs  = 1'b1;
    end else begin
      send_bits(n - 1, 0, v);
      spi_sck = 1'b0;
      tick(2);
      spi_cs = 1'b1;
    end
  endtask

  initial begin
    int f0, v0;
    rst_n = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_miso = 1'b0;
    z_ready = 1'b1; sw_ready = 1'b1;
    tick(3);
    chk("rst_z_data", z_data, 0);
    chk("rst_z_valid", z_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(6);

    // Good frame; latency counted from the edge that first samples cs high.
    frame(24, 32'h00A5_1234, 1'b0);
    tick(3);
    chk("good_valid_early", z_valid, 0);
    tick(1);
    chk("good_valid", z_valid, 1);
    chk("good_data", z_data, 16'h1234);
    chk("good_ferr", frame_err, 0);
    chk("swap_data", sw_data, 16'h3412);
    tick(1);
    chk("good_valid_one_cycle", z_valid, 0);
    tick(4);

    // Short and long frames.
    frame(23, 32'h0052_1A2B, 1'b0);
    tick(4);
    chk("short_ferr", frame_err, 1);
    chk("short_valid", z_valid, 0);
    chk("short_data", z_data, 16'h1234);
    tick(1);
    chk("short_ferr_pulse", frame_err, 0);
    tick(4);
    frame(30, 32'h2AAA_AAAA, 1'b0);
    tick(4);
    chk("long_ferr", frame_err, 1);
    chk("long_valid", z_valid, 0);
    chk("long_data", z_data, 16'h1234);
    tick(1);
    chk("long_ferr_pulse", frame_err, 0);
    tick(4);

    // Backpressure and overrun.
    z_ready = 1'b0;
    frame(24, 32'h00A5_0001, 1'b0);
    tick(4);
    chk("bp1_valid", z_valid, 1);
    chk("bp1_data", z_data, 16'h0001);
    chk("bp1_overrun", overrun, 0);
    tick(4);
    frame(24, 32'h00A5_0002, 1'b0);
    tick(4);
    chk("bp2_valid", z_valid, 1);
    chk("bp2_data", z_data, 16'h0002);
    chk("bp2_overrun", overrun, 1);
    z_ready = 1'b1;
    tick(1);
    chk("bp_accept_valid", z_valid, 0);
    chk("bp_overrun_sticky", overrun, 1);
    tick(4);

    // Reset in the middle of a frame; the tail must not be captured.
    spi_cs = 1'b0;
    tick(4);
    send_bits(23, 14, 32'h00A5_5555);
    spi_sck = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_data", z_data, 0);
    chk("midrst_overrun", overrun, 0);
    tick(2);
    rst_n = 1'b1;
    f0 = n_ferr; v0 = n_vrise;
    send_bits(13, 0, 32'h00A5_5555);
    spi_sck = 1'b0;
    tick(2);
    spi_cs = 1'b1;
    tick(12);
    chk("midrst_no_valid", n_vrise - v0, 0);
    chk("midrst_no_ferr", n_ferr - f0, 0);
    frame(24, 32'h00A5_BEEF, 1'b0);
    tick(4);
    chk("post_rst_valid", z_valid, 1);
    chk("post_rst_data", z_data, 16'hBEEF);
    tick(4);

    // Last sck rise coincident with cs rise.
    f0 = n_ferr;
    frame(24, 32'h00A5_FFFF, 1'b1);
    tick(4);
    chk("coinc_valid", z_valid, 1);
    chk("coinc_data", z_data, 16'hFFFF);
    spi_sck = 1'b0;
    tick(4);
    chk("coinc_no_ferr", n_ferr - f0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
